// File: rtl/spi_read_cache_pkg.sv
// Shared types, defaults and geometry helpers for the SPI read cache.
package spi_read_cache_pkg;

    localparam int LINES_DEF  = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int STAT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        RESP,
        RELEASE
    } state_e;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines);
    endfunction

endpackage

// File: rtl/spi_read_cache_if.sv
// CPU-side and SPI-controller-side handshake bundle; slave is the cache's view.
interface spi_read_cache_if import spi_read_cache_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ready;
    logic              dn_req;
    logic              dn_we;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_wdata;
    logic [7:0]        dn_rdata;
    logic              dn_ready;
    logic              inv;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dn_rdata, dn_ready, inv,
        output cpu_rdata, cpu_ready, dn_req, dn_we, dn_addr, dn_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dn_rdata, dn_ready, inv,
        input  cpu_rdata, cpu_ready, dn_req, dn_we, dn_addr, dn_wdata
    );
endinterface

// File: rtl/spi_cache_tag_store.sv
// Direct-mapped valid/tag/data arrays: combinational lookup, one sync write port, sync clear-all.
module spi_cache_tag_store import spi_read_cache_pkg::*; #(
    parameter  int LINES  = LINES_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int IDX_W  = idx_w(LINES),
    localparam int TAG_W  = tag_w(ADDR_W, LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    output logic [7:0]       rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [7:0]       wr_data_i,
    input  logic             clr_all_i
);
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [7:0]       data_q [LINES];

    assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (clr_all_i) valid_q <= '0;
            if (wr_en_i)   valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only looked at once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/spi_read_cache.sv
// Write-through, write-allocate byte cache between the CPU port and the SPI memory controller.
// Optional SPI_READ_CACHE_STATS_EN adds saturating read hit/miss counters.
module spi_read_cache import spi_read_cache_pkg::*; #(
    parameter int LINES  = LINES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    spi_read_cache_if.slave   bus
`ifdef SPI_READ_CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);

    state_e            state_q, state_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              dn_req_q, dn_req_d;
    logic              dn_we_q, dn_we_d;
    logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]        dn_wdata_q, dn_wdata_d;
    logic              inv_pend_q, inv_pend_d;
    logic              hit, clr_all, wr_en;
    logic [7:0]        hit_data, wr_data;

    spi_cache_tag_store #(.LINES(LINES), .ADDR_W(ADDR_W)) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_idx_i  (bus.cpu_addr[IDX_W-1:0]),
        .rd_tag_i  (bus.cpu_addr[ADDR_W-1:IDX_W]),
        .hit_o     (hit),
        .rd_data_o (hit_data),
        .wr_en_i   (wr_en),
        .wr_idx_i  (dn_addr_q[IDX_W-1:0]),
        .wr_tag_i  (dn_addr_q[ADDR_W-1:IDX_W]),
        .wr_data_i (wr_data),
        .clr_all_i (clr_all)
    );

    assign wr_data = (state_q == FILL) ? bus.dn_rdata : dn_wdata_q;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        dn_req_d   = dn_req_q;
        dn_we_d    = dn_we_q;
        dn_addr_d  = dn_addr_q;
        dn_wdata_d = dn_wdata_q;
        inv_pend_d = inv_pend_q | bus.inv;
        clr_all    = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending or same-cycle invalidate wipes the array and forces a miss.
                clr_all    = bus.inv | inv_pend_q;
                inv_pend_d = 1'b0;
                if (bus.cpu_req) begin
                    if (bus.cpu_we) begin
                        state_d    = WRITE;
                        dn_req_d   = 1'b1;
                        dn_we_d    = 1'b1;
                        dn_addr_d  = bus.cpu_addr;
                        dn_wdata_d = bus.cpu_wdata;
                    end else if (hit && !clr_all) begin
                        state_d = RESP;
                        rdata_d = hit_data;
                    end else begin
                        state_d   = FILL;
                        dn_req_d  = 1'b1;
                        dn_we_d   = 1'b0;
                        dn_addr_d = bus.cpu_addr;
                    end
                end
            end
            FILL: if (bus.dn_ready) begin
                wr_en    = 1'b1;
                rdata_d  = bus.dn_rdata;
                dn_req_d = 1'b0;
                state_d  = RESP;
            end
            WRITE: if (bus.dn_ready) begin
                wr_en    = 1'b1;
                rdata_d  = dn_wdata_q;
                dn_req_d = 1'b0;
                dn_we_d  = 1'b0;
                state_d  = RESP;
            end
            RESP:    state_d = RELEASE;
            RELEASE: if (!bus.cpu_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            dn_req_q   <= 1'b0;
            dn_we_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            dn_req_q   <= dn_req_d;
            dn_we_q    <= dn_we_d;
            dn_addr_q  <= dn_addr_d;
            dn_wdata_q <= dn_wdata_d;
            inv_pend_q <= inv_pend_d;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = (state_q == RESP);
    assign bus.dn_req    = dn_req_q;
    assign bus.dn_we     = dn_we_q;
    assign bus.dn_addr   = dn_addr_q;
    assign bus.dn_wdata  = dn_wdata_q;

`ifdef SPI_READ_CACHE_STATS_EN
    logic              is_rd_q, is_hit_q;
    logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;

    // Classify the access when it leaves IDLE; count it on its RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_rd_q    <= 1'b0;
            is_hit_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && state_d != IDLE) begin
                is_rd_q  <= !bus.cpu_we;
                is_hit_q <= (state_d == RESP);
            end
            if (clr_all) begin
                hit_cnt_q  <= '0;
                miss_cnt_q <= '0;
            end else if (state_q == RESP && is_rd_q) begin
                if (is_hit_q && hit_cnt_q != '1)         hit_cnt_q  <= hit_cnt_q + 1'b1;
                else if (!is_hit_q && miss_cnt_q != '1)  miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_spi_read_cache.sv
// Randomized bench for spi_read_cache against an address-level cache/memory model.
// Stats checks are compiled in when SPI_READ_CACHE_STATS_EN is defined.
module tb_spi_read_cache;
    import spi_read_cache_pkg::*;

    localparam int LINES  = 16;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_read_cache_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef SPI_READ_CACHE_STATS_EN
    logic [STAT_W-1:0] hit_count, miss_count;
`endif

    spi_read_cache #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SPI_READ_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: spi_mem is what the SPI side holds, ref_mem what the CPU should read back,
    // cached[i] the full address currently living in slot i (-1 = empty).
    byte unsigned spi_mem [256];
    byte unsigned ref_mem [256];
    int           cached  [LINES];
    int           m_hits, m_miss;

    int           dn_txn;
    logic [7:0]   dn_last_addr;
    logic         dn_last_we;

    function automatic void m_clear();
        foreach (cached[i]) cached[i] = -1;
        m_hits = 0;
        m_miss = 0;
    endfunction

    // SPI controller model: random 1..4 cycle latency, single-cycle dn_ready.
    initial begin : spi_model
        int cnt, lat;
        bit prev, served;
        cnt = 0; lat = 1; prev = 0; served = 0; dn_txn = 0;
        dn_last_addr = '0; dn_last_we = 1'b0;
        bus.dn_ready = 1'b0;
        bus.dn_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.dn_ready = 1'b0;
            if (reset) begin
                cnt = 0; prev = 0; served = 0;
            end else begin
                if (bus.dn_req && !prev) begin
                    dn_txn++;
                    dn_last_addr = bus.dn_addr;
                    dn_last_we   = bus.dn_we;
                    cnt = 0; served = 0;
                    lat = $urandom_range(1, 4);
                end
                prev = bus.dn_req;
                if (bus.dn_req && !served) begin
                    cnt++;
                    if (cnt >= lat) begin
                        served = 1;
                        bus.dn_ready = 1'b1;
                        if (bus.dn_we) spi_mem[bus.dn_addr] = bus.dn_wdata;
                        else           bus.dn_rdata = spi_mem[bus.dn_addr];
                    end
                end
            end
        end
    end

    // inv_at: -1 none, 0 together with the request, k>0 pulsed k cycles into the access.
    task automatic access(input bit we, input logic [7:0] addr, input logic [7:0] wd, input int inv_at);
        int idx, lat, txn0;
        bit exp_hit, inv_sent;
        logic [7:0] exp_rd;
        idx = int'(addr) % LINES;
        if (inv_at == 0) m_clear();
        exp_hit  = !we && (cached[idx] == int'(addr));
        exp_rd   = we ? wd : ref_mem[addr];
        txn0     = dn_txn;
        inv_sent = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.inv       = (inv_at == 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            bus.inv = (lat == inv_at) && !bus.cpu_ready;
            if (bus.inv) inv_sent = 1;
        end while (!bus.cpu_ready && lat < 50);
        chk("cpu_ready", bus.cpu_ready, 1'b1);
        if (bus.cpu_ready) begin
            chk("cpu_rdata", bus.cpu_rdata, exp_rd);
            if (exp_hit) chk("hit_latency", lat, 1);
            @(posedge clk); #1;
            chk("ready_pulse", bus.cpu_ready, 1'b0);
        end
        bus.cpu_req = 1'b0;
        bus.inv     = 1'b0;
        @(posedge clk); #1;
        chk("dn_txn", dn_txn - txn0, exp_hit ? 0 : 1);
        if (!exp_hit) begin
            chk("dn_addr", dn_last_addr, addr);
            chk("dn_we", dn_last_we, we);
        end
        if (we) chk("spi_wr", spi_mem[addr], wd);
        if (we) ref_mem[addr] = wd;
        else if (exp_hit) m_hits++;
        else m_miss++;
        cached[idx] = int'(addr);
        if (inv_sent) m_clear();
        @(posedge clk); #1;
`ifdef SPI_READ_CACHE_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
`endif
    endtask

    task automatic idle_inv();
        bus.inv = 1'b1;
        @(posedge clk); #1;
        bus.inv = 1'b0;
        m_clear();
        @(posedge clk); #1;
    endtask

    initial begin : main
        int r, a, inv_at;
        bit w;
        for (int i = 0; i < 256; i++) begin
            spi_mem[i] = 8'($urandom);
            ref_mem[i] = spi_mem[i];
        end
        spi_mem[8'h25] = 8'hA7;
        ref_mem[8'h25] = 8'hA7;
        m_clear();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.inv = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        chk("rst_dn_req", bus.dn_req, 1'b0);
        chk("rst_dn_we", bus.dn_we, 1'b0);
        chk("rst_dn_addr", bus.dn_addr, 8'h00);
        chk("rst_dn_wdata", bus.dn_wdata, 8'h00);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss, hit, conflict retag, write-allocate
        access(0, 8'h25, 8'h00, -1);
        access(0, 8'h25, 8'h00, -1);
        access(0, 8'h35, 8'h00, -1);
        access(0, 8'h25, 8'h00, -1);
        access(1, 8'h25, 8'h5C, -1);
        access(0, 8'h25, 8'h00, -1);

        // Invalidate during a fill, then same-cycle invalidate with a request
        access(0, 8'h10, 8'h00, 1);
        access(0, 8'h10, 8'h00, -1);
        access(0, 8'h25, 8'h00, -1);
        access(0, 8'h25, 8'h00, 0);

        // Reset in the middle of a fill
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h47;
        @(posedge clk); #1;
        chk("fill_dn_req", bus.dn_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_dn_req", bus.dn_req, 1'b0);
        chk("midrst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("midrst_dn_addr", bus.dn_addr, 8'h00);
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        m_clear();
        @(posedge clk); #1;

        // One miss then three hits after the reset
        for (int i = 0; i < 4; i++) access(0, 8'h25, 8'h00, -1);
`ifdef SPI_READ_CACHE_STATS_EN
        chk("stats_hits3", hit_count, 3);
        chk("stats_miss1", miss_count, 1);
`endif

        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 63);
            w = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            inv_at = -1;
            if (r == 0) inv_at = 0;
            else if (r == 1 && (w || cached[a % LINES] != a)) inv_at = 1;
            else if (r == 2) idle_inv();
            access(w, 8'(a), 8'($urandom), inv_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
